regulator_hist: RTL and testbench

Multi-channel on/off temperature regulator core. It replaces the single-comparator heater decision with per-channel hysteresis, anti-short-cycle dwell timing and a latched over-temperature fault. Setpoint and measured values are captured on a sample strobe, typically the ADC conversion tick. Heater, fault and state outputs feed the heater drivers and the display path.

---
 rtl/regulator_hist.sv | 159 +++++++++++++++
 tb/tb_regulator_hist.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regulator_hist.sv
// Purpose : multi-channel on/off temperature regulator with hysteresis, dwell hold and latched over-temp fault.
// Latency : inputs captured on the sample edge; heater/fault/state update on the following edge (eval).
// Backpres: none; sample strobes are taken whenever en=1, there is no stall or handshake.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous active-low reset
//   en         regulation enable; low forces ON channels OFF and ignores sample
//   sample     one-cycle capture strobe for setpoint/measured/hyst
//   setpoint   per-channel setpoint, channel i at [i*W +: W]
//   measured   per-channel measured value, same packing
//   hyst       hysteresis shared by all channels
//   fault_ack  per-channel fault clear request
//   heater     heater drive per channel (1 = on)
//   fault      latched over-temperature flag per channel
//   state      per-channel state, channel i at [2i+1:2i]; OFF=00, ON=01, FAULT=10
module regulator_hist #(
    parameter int W         = 8,
    parameter int CH        = 2,
    parameter int MIN_DWELL = 4,
    parameter int OVER      = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              sample,
    input  logic [CH*W-1:0]   setpoint,
    input  logic [CH*W-1:0]   measured,
    input  logic [W-1:0]      hyst,
    input  logic [CH-1:0]     fault_ack,
    output logic [CH-1:0]     heater,
    output logic [CH-1:0]     fault,
    output logic [2*CH-1:0]   state
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Dwell counter needs to hold 0..MIN_DWELL; keep at least one bit so
    // MIN_DWELL=0 still elaborates (the counter then simply stays at 0).
    localparam int DW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [W:0]    MAX_VAL   = {1'b0, {W{1'b1}}};
    localparam logic [W:0]    OVER_X    = (W+1)'(OVER);

    // ---------------------------------------------------------------
    // Capture stage: all FSM decisions work from these registers only.
    // ---------------------------------------------------------------
    logic [CH*W-1:0] sp_q;
    logic [CH*W-1:0] meas_q;
    logic [W-1:0]    hyst_q;
    logic            eval_q;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sp_q   <= '0;
            meas_q <= '0;
            hyst_q <= '0;
            eval_q <= 1'b0;
        end else begin
            eval_q <= sample && en;
            if (sample && en) begin
                sp_q   <= setpoint;
                meas_q <= measured;
                hyst_q <= hyst;
            end
        end
    end

    // ---------------------------------------------------------------
    // Per-channel thresholds and FSM.
    // ---------------------------------------------------------------
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [W:0]    sp_x;
        logic [W:0]    meas_x;
        logic [W:0]    hyst_x;
        logic [W:0]    lo;
        logic [W:0]    hi_raw;
        logic [W:0]    hi;
        logic [W:0]    ov;
        logic          over_temp;
        logic          ack_ok;

        state_t        st_q;
        state_t        st_d;
        logic [DW-1:0] dw_q;
        logic [DW-1:0] dw_d;

        assign sp_x   = {1'b0, sp_q[i*W +: W]};
        assign meas_x = {1'b0, meas_q[i*W +: W]};
        assign hyst_x = {1'b0, hyst_q};

        // lo clamps at 0, so with lo==0 "meas < lo" is never true and the
        // channel cannot turn on. hi clamps at full scale. ov is left
        // unclamped in W+1 bits: once it exceeds full scale no W-bit
        // measurement can reach it and the fault is effectively disabled.
        assign lo        = (sp_x < hyst_x) ? '0 : (sp_x - hyst_x);
        assign hi_raw    = sp_x + hyst_x;
        assign hi        = (hi_raw > MAX_VAL) ? MAX_VAL : hi_raw;
        assign ov        = sp_x + OVER_X;
        assign over_temp = (meas_x >= ov);

        // A fault may only be acknowledged once the registered reading has
        // dropped below the trip point; this also keeps a channel latched
        // when an ack coincides with a fault-triggering eval.
        assign ack_ok    = fault_ack[i] && !over_temp;

        always_ff @(posedge clk) begin
            if (!clr) begin
                st_q <= ST_OFF;
                dw_q <= DWELL_MAX;  // first eval after reset may switch at once
            end else begin
                st_q <= st_d;
                dw_q <= dw_d;
            end
        end

        always_comb begin
            st_d = st_q;
            dw_d = dw_q;
            if (st_q == ST_FAULT) begin
                // Latched regardless of en; only a valid ack releases it.
                if (ack_ok) begin
                    st_d = ST_OFF;
                    dw_d = '0;
                end
            end else if (!en) begin
                // Disable drops heat immediately, bypassing the dwell hold.
                // OFF channels freeze, dwell included.
                if (st_q == ST_ON) begin
                    st_d = ST_OFF;
                    dw_d = '0;
                end
            end else if (eval_q) begin
                if (over_temp) begin
                    st_d = ST_FAULT;
                    dw_d = '0;
                end else if (st_q == ST_OFF && meas_x < lo && dw_q == DWELL_MAX) begin
                    st_d = ST_ON;
                    dw_d = '0;
                end else if (st_q == ST_ON && meas_x >= hi && dw_q == DWELL_MAX) begin
                    st_d = ST_OFF;
                    dw_d = '0;
                end else if (dw_q != DWELL_MAX) begin
                    dw_d = dw_q + DW'(1);
                end
            end
        end

        // Decoded straight from the state register: no input-to-output path.
        assign heater[i]          = (st_q == ST_ON);
        assign fault[i]           = (st_q == ST_FAULT);
        assign state[2*i+1 -: 2]  = st_q;
    end

endmodule

// File: tb/tb_regulator_hist.sv
module tb_regulator_hist;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        sample;
    logic [15:0] setpoint;
    logic [15:0] measured;
    logic [7:0]  hyst;
    logic [1:0]  fault_ack;
    logic [1:0]  heater;
    logic [1:0]  fault;
    logic [3:0]  state;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regulator_hist #(
        .W(8), .CH(2), .MIN_DWELL(2), .OVER(8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .sample    (sample),
        .setpoint  (setpoint),
        .measured  (measured),
        .hyst      (hyst),
        .fault_ack (fault_ack),
        .heater    (heater),
        .fault     (fault),
        .state     (state)
    );

    // Expected values are packed as {heater[1:0], fault[1:0], state[3:0]}.
    localparam logic [7:0] ALL_OFF  = 8'b00_00_0000;
    localparam logic [7:0] CH0_ON   = 8'b01_00_0001;
    localparam logic [7:0] CH0_FLT  = 8'b00_01_0010;
    localparam logic [7:0] CH1_ON   = 8'b10_00_0100;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] expected);
        logic [7:0] observed;
        observed = {heater, fault, state};
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, observed, expected);
        end
    endtask

    // One capture edge followed by the eval edge.
    task automatic do_sample(input logic [7:0] sp0, input logic [7:0] m0,
                             input logic [7:0] sp1, input logic [7:0] m1);
        setpoint = {sp1, sp0};
        measured = {m1, m0};
        sample   = 1'b1;
        tick();
        sample   = 1'b0;
        tick();
    endtask

    initial begin
        // ---- 1. reset with sample pulsing; values that would turn ch0 on
        clr       = 1'b0;
        en        = 1'b1;
        sample    = 1'b1;
        hyst      = 8'd2;
        setpoint  = {8'd100, 8'd100};
        measured  = {8'd100, 8'd97};
        fault_ack = 2'b00;
        tick();
        sample = 1'b0;
        tick();
        sample = 1'b1;
        tick();
        chk("reset_state", ALL_OFF);
        sample = 1'b0;
        clr    = 1'b1;
        tick();
        chk("reset_no_eval", ALL_OFF);

        // ---- 2. hysteresis, with latency check between capture and eval
        setpoint = {8'd100, 8'd100};
        measured = {8'd100, 8'd97};
        sample   = 1'b1;
        tick();
        sample   = 1'b0;
        chk("latency_capture_edge", ALL_OFF);
        tick();
        chk("hyst_turn_on", CH0_ON);
        do_sample(8'd100, 8'd99, 8'd100, 8'd100);
        chk("hyst_hold_99", CH0_ON);
        do_sample(8'd100, 8'd101, 8'd100, 8'd100);
        chk("hyst_hold_101", CH0_ON);
        do_sample(8'd100, 8'd102, 8'd100, 8'd100);
        chk("hyst_off_102", ALL_OFF);

        // ---- 3. dwell: OFF entered with dwell 0, needs 3 evals to switch
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("dwell_off_eval1", ALL_OFF);
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("dwell_off_eval2", ALL_OFF);
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("dwell_on_eval3", CH0_ON);
        do_sample(8'd100, 8'd105, 8'd100, 8'd100);
        chk("dwell_on_hold1", CH0_ON);
        do_sample(8'd100, 8'd105, 8'd100, 8'd100);
        chk("dwell_on_hold2", CH0_ON);
        do_sample(8'd100, 8'd105, 8'd100, 8'd100);
        chk("dwell_off_eval3", ALL_OFF);

        // ---- 4. fault: get ON with dwell 0, then over-temperature
        for (int k = 0; k < 3; k++) do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("fault_prep_on", CH0_ON);
        do_sample(8'd100, 8'd108, 8'd100, 8'd100);
        chk("fault_trip", CH0_FLT);
        fault_ack = 2'b01;
        tick();
        fault_ack = 2'b00;
        chk("fault_ack_ignored", CH0_FLT);
        do_sample(8'd100, 8'd90, 8'd100, 8'd100);
        chk("fault_latched_cool", CH0_FLT);
        fault_ack = 2'b01;
        tick();
        fault_ack = 2'b00;
        chk("fault_ack_clears", ALL_OFF);
        do_sample(8'd100, 8'd90, 8'd100, 8'd100);
        chk("post_ack_eval1", ALL_OFF);
        do_sample(8'd100, 8'd90, 8'd100, 8'd100);
        chk("post_ack_eval2", ALL_OFF);
        do_sample(8'd100, 8'd90, 8'd100, 8'd100);
        chk("post_ack_eval3_on", CH0_ON);

        // ---- 5. clamps: hi clamps to 255, ov=262 is out of range
        do_sample(8'd254, 8'd255, 8'd100, 8'd100);
        chk("clamp_hi_no_fault1", CH0_ON);
        do_sample(8'd254, 8'd255, 8'd100, 8'd100);
        chk("clamp_hi_no_fault2", CH0_ON);
        do_sample(8'd254, 8'd255, 8'd100, 8'd100);
        chk("clamp_hi_off", ALL_OFF);
        do_sample(8'd250, 8'd255, 8'd100, 8'd100);
        chk("clamp_ov_258", ALL_OFF);
        for (int k = 0; k < 3; k++) do_sample(8'd1, 8'd0, 8'd100, 8'd100);
        chk("clamp_lo_zero", ALL_OFF);

        // ---- 6. independence and enable
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("indep_ch0_on", CH0_ON);
        en = 1'b0;
        tick();
        chk("en_low_forces_off", ALL_OFF);
        do_sample(8'd100, 8'd97, 8'd100, 8'd97);
        chk("en_low_sample_ignored", ALL_OFF);
        en = 1'b1;
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("en_off_dwell_cleared", ALL_OFF);
        do_sample(8'd100, 8'd97, 8'd100, 8'd97);
        chk("indep_ch1_on", CH1_ON);

        // ---- reset while a channel is ON, then dwell reloads to MIN_DWELL
        clr = 1'b0;
        tick();
        chk("reset_while_on", ALL_OFF);
        clr = 1'b1;
        do_sample(8'd100, 8'd97, 8'd100, 8'd100);
        chk("reset_dwell_reload", CH0_ON);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
